// File: rtl/rca_pkg.sv
// Shared definitions for the pipelined ripple-carry adder/subtractor.
package rca_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Bits resolved per pipeline stage.
  function automatic int chunk_width(input int width, input int stages);
    return (stages > 0) ? (width / stages) : 1;
  endfunction

  // True when the WIDTH/STAGES pair cannot be split into equal slices.
  function automatic bit cfg_invalid(input int width, input int stages);
    return (stages < 1) || (stages > width) || ((width % stages) != 0);
  endfunction

endpackage

// File: rtl/rca_pipelined_if.sv
// Operand/result bus of the pipelined adder/subtractor.
interface rca_pipelined_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             sub;
  logic             out_valid;
  logic [WIDTH:0]   Q;
  logic             ovf;

  modport master (
    output in_valid, A, B, Cin, sub,
    input  out_valid, Q, ovf
  );

  modport slave (
    input  in_valid, A, B, Cin, sub,
    output out_valid, Q, ovf
  );
endinterface

// File: rtl/rca_pipe_stage.sv
// One pipeline stage: ripples CHUNK bits of the sum starting at slice IDX,
// then registers the partial sum, carry, operands and sign bits.
module rca_pipe_stage #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4,
  parameter int IDX   = 0,
  parameter bit LAST  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             vld_i,
  input  logic             c_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] sum_i,
  input  logic             sa_i,
  input  logic             sb_i,
  input  logic             ovf_i,
  output logic             vld_o,
  output logic             c_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             sa_o,
  output logic             sb_o,
  output logic             ovf_o
);

  localparam int LO = IDX * CHUNK;

  logic             vld_q;
  logic             c_q, c_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             sa_q, sb_q;
  logic             ovf_q, ovf_d;
  logic             carry;
  logic             load;

  // Ripple this stage's slice; the final stage also derives signed overflow
  // from the now-complete MSB, earlier stages just pass ovf along.
  always_comb begin
    sum_d = sum_i;
    carry = c_i;
    for (int j = 0; j < CHUNK; j++) begin
      sum_d[LO+j] = a_i[LO+j] ^ b_i[LO+j] ^ carry;
      carry       = (a_i[LO+j] & b_i[LO+j]) | (carry & (a_i[LO+j] ^ b_i[LO+j]));
    end
    c_d   = carry;
    ovf_d = LAST ? ((sa_i == sb_i) && (sum_d[WIDTH-1] != sa_i)) : ovf_i;
  end

  // The output stage keeps its last valid result when a bubble arrives.
  assign load = vld_i || !LAST;

  // Stage registers: reset clears everything, enable=0 freezes everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= 1'b0;
      c_q   <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else if (enable) begin
      vld_q <= vld_i;
      if (load) begin
        c_q   <= c_d;
        a_q   <= a_i;
        b_q   <= b_i;
        sum_q <= sum_d;
        sa_q  <= sa_i;
        sb_q  <= sb_i;
        ovf_q <= ovf_d;
      end
    end
  end

  assign vld_o = vld_q;
  assign c_o   = c_q;
  assign a_o   = a_q;
  assign b_o   = b_q;
  assign sum_o = sum_q;
  assign sa_o  = sa_q;
  assign sb_o  = sb_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/rca_pipelined.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits split into STAGES equal
// slices, one slice per stage, with valid tracking and signed overflow.
module rca_pipelined
  import rca_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  rca_pipelined_if.slave bus
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);
  localparam bit BAD   = cfg_invalid(WIDTH, STAGES);

  if (BAD) begin : g_cfg_error
    $error("rca_pipelined: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
  end

  logic             vld_s [0:STAGES];
  logic             c_s   [0:STAGES];
  logic [WIDTH-1:0] a_s   [0:STAGES];
  logic [WIDTH-1:0] b_s   [0:STAGES];
  logic [WIDTH-1:0] sum_s [0:STAGES];
  logic             sa_s  [0:STAGES];
  logic             sb_s  [0:STAGES];
  logic             ovf_s [0:STAGES];
  logic             unused_tail;

  // Input capture: subtraction feeds ~B and ~Cin so the slices only ever add.
  assign vld_s[0] = bus.in_valid;
  assign a_s[0]   = bus.A;
  assign b_s[0]   = (bus.sub == MODE_SUB) ? ~bus.B : bus.B;
  assign c_s[0]   = (bus.sub == MODE_SUB) ? ~bus.Cin : bus.Cin;
  assign sum_s[0] = '0;
  assign sa_s[0]  = a_s[0][WIDTH-1];
  assign sb_s[0]  = b_s[0][WIDTH-1];
  assign ovf_s[0] = 1'b0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    rca_pipe_stage #(
      .WIDTH(WIDTH),
      .CHUNK(CHUNK),
      .IDX  (k),
      .LAST (k == STAGES - 1)
    ) u_stage (
      .clk   (clk),
      .reset (reset),
      .enable(enable),
      .vld_i (vld_s[k]),
      .c_i   (c_s[k]),
      .a_i   (a_s[k]),
      .b_i   (b_s[k]),
      .sum_i (sum_s[k]),
      .sa_i  (sa_s[k]),
      .sb_i  (sb_s[k]),
      .ovf_i (ovf_s[k]),
      .vld_o (vld_s[k+1]),
      .c_o   (c_s[k+1]),
      .a_o   (a_s[k+1]),
      .b_o   (b_s[k+1]),
      .sum_o (sum_s[k+1]),
      .sa_o  (sa_s[k+1]),
      .sb_o  (sb_s[k+1]),
      .ovf_o (ovf_s[k+1])
    );
  end

  // Operands leaving the last stage have nothing left to feed.
  assign unused_tail = ^{a_s[STAGES], b_s[STAGES], sa_s[STAGES], sb_s[STAGES]};

  assign bus.out_valid = vld_s[STAGES];
  assign bus.Q         = {c_s[STAGES], sum_s[STAGES]};
  assign bus.ovf       = ovf_s[STAGES];

endmodule
